csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file; completer side of the pipeline's CSR channel.
//  Decodes CSR read/modify/write requests, performs synchronous trap entry and mret,
//  and keeps the 64-bit cycle/instret counters.
//  Feeds the fetch stage the redirect targets trap_vector and epc.
//  Feeds interrupt logic irq_enable.
// PARAMETERS
//  HART_ID      0             value returned by mhartid (0xF14)
//  MISA_VALUE   32'h40000100  value returned by misa (0x301), RV32I; writes ignored, not illegal
//  MTVEC_RESET  32'h00000000  reset value of mtvec; bits [1:0] forced 0
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  csr_valid      in   1   CSR instruction request this cycle
//  csr_op         in   2   01 RW, 10 RS (set), 11 RC (clear), 00 no-op
//  csr_addr       in   12  CSR address
//  csr_wdata      in   32  rs1 value or zero-extended zimm
//  csr_no_write   in   1   1 = RS/RC with rs1=x0 / zimm=0: read only, no write side effects
//  instr_retire   in   1   one instruction retires this cycle
//  trap_valid     in   1   take synchronous trap this cycle
//  trap_cause     in   32  mcause value
//  trap_pc        in   32  faulting PC
//  trap_tval      in   32  mtval value
//  mret           in   1   mret retires this cycle
//  csr_rdata      out  32  old CSR value, combinational
//  csr_illegal    out  1   illegal CSR access, combinational
//  trap_vector    out  32  {mtvec[31:2],2'b00}, direct mode only
//  epc            out  32  mepc
//  irq_enable     out  1   mstatus.MIE
// BEHAVIOUR
//  Reset (async): mstatus.MIE=0, MPIE=0; mtvec=MTVEC_RESET; all other regs and counters=0.
//    Outputs follow the regs: irq_enable=0, epc=0, trap_vector=MTVEC_RESET&~3.
//  Implemented CSRs:
//    mstatus 0x300: MIE bit3, MPIE bit7, MPP [12:11] reads 2'b11; other bits read 0.
//    misa 0x301; mtvec 0x305; mscratch 0x340.
//    mepc 0x341: bits [1:0] forced 0. mcause 0x342; mtval 0x343; mhartid 0xF14.
//  Read: csr_rdata = current (pre-write) value, same cycle as csr_valid.
//    csr_rdata=0 when csr_valid=0 or the access is illegal.
//  Write, applied at next rising edge when csr_valid & op!=00 & !csr_illegal & !trap_valid:
//    RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
//    RS/RC with csr_no_write=1 perform no write. RW always writes.
//  Illegal when csr_valid & op!=00 and either:
//    - the address is unimplemented; or
//    - addr[11:10]==2'b11 (read-only space) and a write is effective (RW, or RS/RC with !csr_no_write).
//  Trap entry (trap_valid at edge):
//    mepc<=trap_pc&~3; mcause<=trap_cause; mtval<=trap_tval; MPIE<=MIE; MIE<=0.
//  mret (at edge, no trap): MIE<=MPIE; MPIE<=1.
//  Priority on the same edge: trap_valid > mret > CSR write. Lower-priority actions are dropped entirely.
//  Counters: 64-bit mcycle increments every cycle out of reset; 64-bit minstret increments on instr_retire.
//    Low-half carry propagates to the high half; wrap 2^64-1 -> 0.
//    A CSR write to a counter half wins over that counter's increment on the same edge.
//    The other half is unchanged that edge, with no carry into it.
//  No state carries across reset; a trap or write in flight at reset assertion is lost.
// CONFIGURATION
//  CSR_COUNTERS_EN defined:
//    - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: read/write.
//    - cycle 0xC00 / cycleh 0xC80, instret 0xC02 / instreth 0xC82: read-only aliases.
//  CSR_COUNTERS_EN undefined:
//    - no counter flops are built; instr_retire is ignored;
//    - all eight counter addresses are unimplemented, so any access is illegal.
// TESTING
//  1. Reset, then read mstatus -> rdata=0x00001800; irq_enable=0; trap_vector=MTVEC_RESET.
//  2. RW mscratch 0xDEADBEEF; RS 0x0000000F; RC 0xDEADBEE0 -> successive reads return
//     0xDEADBEEF, then 0xDEADBEEF (before RC), final value 0x0000000F.
//  3. MIE=1; trap cause=2, pc=0x1002, tval=0x13 -> mepc=0x1000, mcause=2, MIE=0, MPIE=1.
//     Then mret -> MIE=1, MPIE=1.
//  4. Same edge: trap_valid plus RW mtvec 0x200 -> trap taken, mtvec unchanged.
//  5. RW to 0xF14 -> csr_illegal=1, no state change.
//     RS with csr_no_write=1 to 0xF14 -> legal, rdata=HART_ID.
//     Access to 0x7C0 -> csr_illegal=1.
//  6. CSR_COUNTERS_EN: write mcycle=0xFFFFFFFF -> mcycleh increments on the following edge.
//     Write minstret while instr_retire=1 -> written value, no +1.
//     Without the macro, a read of 0xC00 is illegal.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file with trap entry, mret and CSR read/modify/write.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their read-only aliases.
module csr_file #(
   parameter logic [31:0] HART_ID     = 32'h00000000,
   parameter logic [31:0] MISA_VALUE  = 32'h40000100,
   parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_valid,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        csr_no_write,
   input  logic        instr_retire,
   input  logic        trap_valid,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   output logic [31:0] trap_vector,
   output logic [31:0] epc,
   output logic        irq_enable
);

   localparam logic [1:0]  OP_NONE    = 2'b00;
   localparam logic [1:0]  OP_RW      = 2'b01;
   localparam logic [1:0]  OP_RS      = 2'b10;
   localparam logic [1:0]  OP_RC      = 2'b11;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

   logic        mie_r;
   logic        mpie_r;
   logic [29:0] mtvec_r;
   logic [29:0] mepc_r;
   logic [31:0] mscratch_r;
   logic [31:0] mcause_r;
   logic [31:0] mtval_r;
`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_r;
   logic [63:0] minstret_r;
`endif

   logic        impl_s;
   logic [31:0] old_s;
   logic [31:0] new_s;
   logic        access_s;
   logic        effective_s;
   logic        illegal_s;
   logic        write_s;

   // Address decode and pre-write value of the addressed CSR.
   always_comb begin
      impl_s = 1'b1;
      old_s  = 32'h00000000;
      case (csr_addr)
         A_MSTATUS:  old_s = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};
         A_MISA:     old_s = MISA_VALUE;
         A_MTVEC:    old_s = {mtvec_r, 2'b00};
         A_MSCRATCH: old_s = mscratch_r;
         A_MEPC:     old_s = {mepc_r, 2'b00};
         A_MCAUSE:   old_s = mcause_r;
         A_MTVAL:    old_s = mtval_r;
         A_MHARTID:  old_s = HART_ID;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE,    A_CYCLE:    old_s = mcycle_r[31:0];
         A_MCYCLEH,   A_CYCLEH:   old_s = mcycle_r[63:32];
         A_MINSTRET,  A_INSTRET:  old_s = minstret_r[31:0];
         A_MINSTRETH, A_INSTRETH: old_s = minstret_r[63:32];
`endif
         default: begin
            impl_s = 1'b0;
            old_s  = 32'h00000000;
         end
      endcase
   end

   // Read-modify-write value for the requested operation.
   always_comb begin
      case (csr_op)
         OP_RW:   new_s = csr_wdata;
         OP_RS:   new_s = old_s | csr_wdata;
         OP_RC:   new_s = old_s & ~csr_wdata;
         default: new_s = old_s;
      endcase
   end

   // A write is dropped when a trap or mret claims the same edge.
   assign access_s    = csr_valid & (csr_op != OP_NONE);
   assign effective_s = (csr_op == OP_RW) | ~csr_no_write;
   assign illegal_s   = access_s & (~impl_s | ((csr_addr[11:10] == 2'b11) & effective_s));
   assign write_s     = access_s & effective_s & ~illegal_s & ~trap_valid & ~mret;

   assign csr_illegal = illegal_s;
   assign csr_rdata   = (csr_valid & ~illegal_s) ? old_s : 32'h00000000;
   assign trap_vector = {mtvec_r, 2'b00};
   assign epc         = {mepc_r, 2'b00};
   assign irq_enable  = mie_r;

   // Machine status and trap state: trap entry beats mret beats a CSR write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie_r      <= 1'b0;
         mpie_r     <= 1'b0;
         mtvec_r    <= MTVEC_RESET[31:2];
         mepc_r     <= 30'd0;
         mscratch_r <= 32'h00000000;
         mcause_r   <= 32'h00000000;
         mtval_r    <= 32'h00000000;
      end else if (trap_valid) begin
         mepc_r   <= trap_pc[31:2];
         mcause_r <= trap_cause;
         mtval_r  <= trap_tval;
         mpie_r   <= mie_r;
         mie_r    <= 1'b0;
      end else if (mret) begin
         mie_r  <= mpie_r;
         mpie_r <= 1'b1;
      end else if (write_s) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie_r  <= new_s[3];
               mpie_r <= new_s[7];
            end
            A_MTVEC:    mtvec_r    <= new_s[31:2];
            A_MSCRATCH: mscratch_r <= new_s;
            A_MEPC:     mepc_r     <= new_s[31:2];
            A_MCAUSE:   mcause_r   <= new_s;
            A_MTVAL:    mtval_r    <= new_s;
            default:    mscratch_r <= mscratch_r;
         endcase
      end else begin
         mie_r <= mie_r;
      end
   end

`ifdef CSR_COUNTERS_EN
   // Counters: a write to either half replaces that half and suppresses the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcycle_r   <= 64'd0;
         minstret_r <= 64'd0;
      end else begin
         if (write_s && (csr_addr == A_MCYCLE)) begin
            mcycle_r[31:0] <= new_s;
         end else if (write_s && (csr_addr == A_MCYCLEH)) begin
            mcycle_r[63:32] <= new_s;
         end else begin
            mcycle_r <= mcycle_r + 64'd1;
         end

         if (write_s && (csr_addr == A_MINSTRET)) begin
            minstret_r[31:0] <= new_s;
         end else if (write_s && (csr_addr == A_MINSTRETH)) begin
            minstret_r[63:32] <= new_s;
         end else if (instr_retire) begin
            minstret_r <= minstret_r + 64'd1;
         end else begin
            minstret_r <= minstret_r;
         end
      end
   end

   logic unused_s;
   assign unused_s = ^trap_pc[1:0];
`else
   logic unused_s;
   assign unused_s = ^{instr_retire, trap_pc[1:0]};
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed test of csr_file against a behavioural CSR model checked every cycle.
// Counter tests follow CSR_COUNTERS_EN, matching the DUT build.
module tb_csr_file;

   localparam logic [31:0] HART_ID     = 32'h00000007;
   localparam logic [31:0] MISA_VALUE  = 32'h40000100;
   localparam logic [31:0] MTVEC_RESET = 32'h00000103;

   logic        clk;
   logic        reset;
   logic        csr_valid;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_no_write;
   logic        instr_retire;
   logic        trap_valid;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic [31:0] trap_vector;
   logic [31:0] epc;
   logic        irq_enable;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state
   logic        m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cycle, m_instret;

   csr_file #(.HART_ID(HART_ID), .MISA_VALUE(MISA_VALUE), .MTVEC_RESET(MTVEC_RESET)) dut (
      .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_no_write(csr_no_write), .instr_retire(instr_retire),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret(mret), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_vector(trap_vector),
      .epc(epc), .irq_enable(irq_enable)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mie = 1'b0; m_mpie = 1'b0;
      m_mtvec = MTVEC_RESET & ~32'h3;
      m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
      m_cycle = 64'd0; m_instret = 64'd0;
   endtask

   function automatic bit m_impl(input logic [11:0] a);
      case (a)
         12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h00001800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
         12'h301: return MISA_VALUE;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'hF14: return HART_ID;
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_illegal();
      bit eff;
      eff = (csr_op == 2'b01) || !csr_no_write;
      return csr_valid && (csr_op != 2'b00) &&
             (!m_impl(csr_addr) || ((csr_addr[11:10] == 2'b11) && eff));
   endfunction

   // Model update on each clock edge out of reset.
   task automatic model_step();
      logic [31:0] old, nv;
      bit wr, cyc_wr, ins_wr;
      old = m_read(csr_addr);
      case (csr_op)
         2'b01:   nv = csr_wdata;
         2'b10:   nv = old | csr_wdata;
         2'b11:   nv = old & ~csr_wdata;
         default: nv = old;
      endcase
      wr = csr_valid && (csr_op != 2'b00) && ((csr_op == 2'b01) || !csr_no_write)
           && !m_illegal() && !trap_valid && !mret;
      cyc_wr = 1'b0;
      ins_wr = 1'b0;
      if (trap_valid) begin
         m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
         m_mpie = m_mie; m_mie = 1'b0;
      end else if (mret) begin
         m_mie = m_mpie; m_mpie = 1'b1;
      end else if (wr) begin
         case (csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = nv & ~32'h3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
`ifdef CSR_COUNTERS_EN
            12'hB00: begin m_cycle = {m_cycle[63:32], nv}; cyc_wr = 1'b1; end
            12'hB80: begin m_cycle = {nv, m_cycle[31:0]}; cyc_wr = 1'b1; end
            12'hB02: begin m_instret = {m_instret[63:32], nv}; ins_wr = 1'b1; end
            12'hB82: begin m_instret = {nv, m_instret[31:0]}; ins_wr = 1'b1; end
`endif
            default: ;
         endcase
      end
      if (!cyc_wr) m_cycle = m_cycle + 64'd1;
      if (!ins_wr && instr_retire) m_instret = m_instret + 64'd1;
   endtask

   always @(posedge clk) begin
      if (!reset) model_step();
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      bit ill;
      ill = m_illegal();
      check("csr_illegal", {31'd0, csr_illegal}, {31'd0, ill});
      check("csr_rdata", csr_rdata, (csr_valid && !ill) ? m_read(csr_addr) : 32'h0);
      check("trap_vector", trap_vector, m_mtvec);
      check("epc", epc, m_mepc);
      check("irq_enable", {31'd0, irq_enable}, {31'd0, m_mie});
   end

   task automatic clr();
      csr_valid = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = 32'h0;
      csr_no_write = 1'b0; instr_retire = 1'b0; trap_valid = 1'b0; trap_cause = 32'h0;
      trap_pc = 32'h0; trap_tval = 32'h0; mret = 1'b0;
   endtask

   task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input logic nw);
      clr();
      csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd; csr_no_write = nw;
   endtask

   task automatic rd(input logic [11:0] a);
      drive(2'b10, a, 32'h0, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      clr();
      reset = 1'b1;
      model_reset();
      settle();
      check("rst_irq_enable", {31'd0, irq_enable}, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_trap_vector", trap_vector, 32'h00000100);
      tick(); tick();
      reset = 1'b0;

      // Reset state of mstatus
      rd(12'h300); settle();
      check("mstatus_reset", csr_rdata, 32'h00001800);
      tick();

      // mscratch read/set/clear
      drive(2'b01, 12'h340, 32'hDEADBEEF, 1'b0); settle();
      check("mscratch_rw_old", csr_rdata, 32'h0); tick();
      drive(2'b10, 12'h340, 32'h0000000F, 1'b0); instr_retire = 1'b1; settle();
      check("mscratch_rs_old", csr_rdata, 32'hDEADBEEF); tick();
      drive(2'b11, 12'h340, 32'hDEADBEE0, 1'b0); instr_retire = 1'b1; settle();
      check("mscratch_rc_old", csr_rdata, 32'hDEADBEEF); tick();
      rd(12'h340); settle();
      check("mscratch_final", csr_rdata, 32'h0000000F); tick();

      // Trap entry then mret
      drive(2'b10, 12'h300, 32'h00000008, 1'b0); tick();
      clr(); settle();
      check("mie_set", {31'd0, irq_enable}, 32'h1);
      trap_valid = 1'b1; trap_cause = 32'h2; trap_pc = 32'h1002; trap_tval = 32'h13; tick();
      rd(12'h341); settle();
      check("mepc_trap", csr_rdata, 32'h00001000);
      check("epc_trap", epc, 32'h00001000);
      check("mie_trap", {31'd0, irq_enable}, 32'h0); tick();
      rd(12'h342); settle(); check("mcause_trap", csr_rdata, 32'h2); tick();
      rd(12'h343); settle(); check("mtval_trap", csr_rdata, 32'h13); tick();
      rd(12'h300); settle(); check("mstatus_trap", csr_rdata, 32'h00001880); tick();
      clr(); mret = 1'b1; tick();
      rd(12'h300); settle(); check("mstatus_mret", csr_rdata, 32'h00001888); tick();

      // Trap beats a CSR write on the same edge; mret beats a CSR write too
      drive(2'b01, 12'h305, 32'h00000200, 1'b0);
      trap_valid = 1'b1; trap_cause = 32'h3; trap_pc = 32'h2000; tick();
      rd(12'h305); settle();
      check("mtvec_kept", csr_rdata, 32'h00000100);
      check("epc_trap2", epc, 32'h00002000); tick();
      drive(2'b01, 12'h340, 32'h00000055, 1'b0); mret = 1'b1; tick();
      rd(12'h340); settle();
      check("mscratch_mret", csr_rdata, 32'h0000000F);
      check("mie_mret2", {31'd0, irq_enable}, 32'h1); tick();

      // Read-only and unimplemented addresses
      drive(2'b01, 12'hF14, 32'h5, 1'b0); settle();
      check("hartid_rw_ill", {31'd0, csr_illegal}, 32'h1);
      check("hartid_rw_rdata", csr_rdata, 32'h0); tick();
      rd(12'hF14); settle();
      check("hartid_rs_ill", {31'd0, csr_illegal}, 32'h0);
      check("hartid_rs_rdata", csr_rdata, 32'h00000007); tick();
      rd(12'h7C0); settle();
      check("unimpl_ill", {31'd0, csr_illegal}, 32'h1); tick();
      drive(2'b01, 12'h301, 32'h0, 1'b0); tick();
      rd(12'h301); settle(); check("misa_ro", csr_rdata, 32'h40000100); tick();
      drive(2'b01, 12'h305, 32'h12345677, 1'b0); tick();
      clr(); settle(); check("mtvec_mask", trap_vector, 32'h12345674); tick();
      drive(2'b01, 12'h341, 32'hABCD0003, 1'b0); tick();
      clr(); settle(); check("mepc_mask", epc, 32'hABCD0000); tick();

`ifdef CSR_COUNTERS_EN
      // Counter writes, carry, and increment suppression
      drive(2'b01, 12'hB00, 32'hFFFFFFFF, 1'b0); tick();
      rd(12'hB00); settle(); check("mcycle_wr", csr_rdata, 32'hFFFFFFFF);
      check("mcycleh_pre", m_read(12'hB80), 32'h0); tick();
      rd(12'hC80); settle(); check("cycleh_carry", csr_rdata, 32'h1); tick();
      drive(2'b01, 12'hB80, 32'h0000000A, 1'b0); tick();
      rd(12'hB80); settle(); check("mcycleh_wr", csr_rdata, 32'hA); tick();
      drive(2'b01, 12'hB02, 32'h00000100, 1'b0); instr_retire = 1'b1; tick();
      rd(12'hC02); settle(); check("minstret_wr", csr_rdata, 32'h00000100); tick();
      drive(2'b01, 12'hC00, 32'h0, 1'b0); settle();
      check("cycle_ro_ill", {31'd0, csr_illegal}, 32'h1); tick();
`else
      rd(12'hC00); instr_retire = 1'b1; settle();
      check("cycle_unimpl", {31'd0, csr_illegal}, 32'h1); tick();
      rd(12'hB00); settle();
      check("mcycle_unimpl", {31'd0, csr_illegal}, 32'h1); tick();
`endif

      // Asynchronous reset mid-run
      clr();
      @(posedge clk); #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("arst_irq_enable", {31'd0, irq_enable}, 32'h0);
      check("arst_trap_vector", trap_vector, 32'h00000100);
      check("arst_epc", epc, 32'h0);
      tick();
      reset = 1'b0;
      rd(12'h340); settle(); check("arst_mscratch", csr_rdata, 32'h0); tick();
      clr(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
